// File: rtl/tft_pkg.sv
// tft_pkg
//   Shared definitions for the TFT display path: SPI payload width,
//   bus-arbiter state encoding and the data/command flag values that
//   travel on the dc line alongside each byte.
//   No ports (package).

package tft_pkg;

    localparam int TFT_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/tft_bus_arbiter_if.sv
// tft_bus_arbiter_if
//   Bundles the requester side and the tft_spi side of the bus arbiter.
//   Parameters: NUM_REQ requesters, BYTE_W payload width.
//   Signals:
//     req, req_data, req_dc, req_transmit : from requesters
//     gnt, req_busy                       : back to requesters
//     spi_busy                            : from tft_spi
//     spi_data, spi_dc, spi_transmit      : to tft_spi
//     err                                 : sticky dropped-transmit flag
//   Modports: master = requesters/tft_spi side, slave = arbiter.

interface tft_bus_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int BYTE_W  = tft_pkg::TFT_BYTE_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_dc;
    logic [NUM_REQ-1:0]        req_transmit;
    logic [NUM_REQ-1:0]        gnt;
    logic                      req_busy;
    logic                      spi_busy;
    logic [BYTE_W-1:0]         spi_data;
    logic                      spi_dc;
    logic                      spi_transmit;
    logic                      err;

    modport master (
        output req, req_data, req_dc, req_transmit, spi_busy,
        input  gnt, req_busy, spi_data, spi_dc, spi_transmit, err
    );

    modport slave (
        input  req, req_data, req_dc, req_transmit, spi_busy,
        output gnt, req_busy, spi_data, spi_dc, spi_transmit, err
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches req starting at
//   last_owner+1 (wrapping modulo NUM_REQ) and returns the first set bit.
//   Ports:
//     req        in  NUM_REQ  request vector
//     last_owner in  IDX_W    index granted most recently
//     owner      out IDX_W    chosen index (0 when valid=0)
//     valid      out 1        at least one request is set

module rr_pick
    import tft_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   owner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit after
    // last_owner is the one left standing.
    always_comb begin
        owner = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (req[idx]) begin
                owner = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter
//   Shares one tft_spi byte transmitter between NUM_REQ requesters.
//   Round-robin grants that last a whole burst (while req is held),
//   registered byte/dc/transmit toward tft_spi, merged busy back to the
//   requesters, and a sticky err flag for every dropped transmit.
//   Ports:
//     clk  in  system clock
//     rst  in  asynchronous reset, active-low
//     bus  slave modport of tft_bus_arbiter_if (requesters + tft_spi)

module tft_bus_arbiter
    import tft_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int BYTE_W  = TFT_BYTE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    tft_bus_arbiter_if.slave     bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (idx == IDX_W'(i));
        end
        return v;
    endfunction

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   owner;      // doubles as last_owner for the picker
    logic [IDX_W-1:0]   pick_owner;
    logic               pick_valid;

    logic [NUM_REQ-1:0] owner_sel;
    logic               owner_req;
    logic               owner_tx;
    logic               other_tx;
    logic [BYTE_W-1:0]  owner_data;
    logic               owner_dc;
    logic               accept;
    logic               drop;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req),
        .last_owner (owner),
        .owner      (pick_owner),
        .valid      (pick_valid)
    );

    // spi_transmit is folded in so the cycle the pulse is out counts as busy,
    // covering the gap before tft_spi raises spi_busy.
    assign bus.req_busy = bus.spi_busy | bus.spi_transmit;

    // Owner-side view of the request bus.
    always_comb begin
        owner_sel  = onehot(owner);
        owner_req  = |(bus.req & owner_sel);
        owner_tx   = |(bus.req_transmit & owner_sel);
        other_tx   = |(bus.req_transmit & ~owner_sel);
        owner_data = '0;
        owner_dc   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_sel[i]) begin
                owner_data = bus.req_data[i*BYTE_W +: BYTE_W];
                owner_dc   = bus.req_dc[i];
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_valid)    state_nxt = ARB_GRANT;
            ARB_GRANT: if (!owner_req)    state_nxt = ARB_DRAIN;
            ARB_DRAIN: if (!bus.req_busy) state_nxt = ARB_IDLE;
            default:                      state_nxt = ARB_IDLE;
        endcase
    end

    // FSM: outputs. Only the owner may send, and only while the line is free;
    // a transmit in the same cycle the owner drops req is still honoured.
    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        case (state)
            ARB_GRANT: begin
                accept = owner_tx & ~bus.req_busy;
                drop   = other_tx | (owner_tx & bus.req_busy);
            end
            default: begin
                drop   = |bus.req_transmit;
            end
        endcase
    end

    // Grant and owner registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= LAST_IDX;
            bus.gnt <= '0;
        end else if (state == ARB_IDLE && pick_valid) begin
            owner   <= pick_owner;
            bus.gnt <= onehot(pick_owner);
        end else if (state != ARB_GRANT || !owner_req) begin
            bus.gnt <= '0;
        end
    end

    // Toward tft_spi; byte and dc hold the last sent value between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.spi_data     <= '0;
            bus.spi_dc       <= 1'b0;
            bus.spi_transmit <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            bus.spi_transmit <= accept;
            bus.err          <= bus.err | drop;
            if (accept) begin
                bus.spi_data <= owner_data;
                bus.spi_dc   <= owner_dc;
            end
        end
    end

endmodule
